// File: rtl/id_decode_stage.sv
// MIPS decode stage: a 32x32 register file with write-before-read bypass, a decoder
// for addu/subu/sll/sllv/slti, and a single registered output entry with valid/ready handshake.
module id_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [4:0]  rd_out,
  output logic        illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RIDX  = 5;
  localparam int unsigned FNW   = 6;
  localparam int unsigned NREG  = 32;
  localparam int unsigned IMMW  = 16;

  localparam logic [FNW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [FNW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [FNW-1:0] FN_ADDU  = 6'b100001;
  localparam logic [FNW-1:0] FN_SUBU  = 6'b100011;
  localparam logic [FNW-1:0] FN_SLL   = 6'b000000;
  localparam logic [FNW-1:0] FN_SLLV  = 6'b000100;

  localparam logic [FNW-1:0] ALU_ADDU = 6'b001001;
  localparam logic [FNW-1:0] ALU_SUBU = 6'b001010;
  localparam logic [FNW-1:0] ALU_SLL  = 6'b100001;
  localparam logic [FNW-1:0] ALU_SLLV = 6'b110101;
  localparam logic [FNW-1:0] ALU_SLTI = 6'b101010;

  typedef struct packed {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [RIDX-1:0] shamt;
    logic [FNW-1:0]  funct;
    logic [RIDX-1:0] rd;
    logic            illegal;
  } dec_t;

  logic [XLEN-1:0] regs [NREG];
  logic [RIDX-1:0] rs, rt, rd;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [FNW-1:0]  opcode, fn_field;
  dec_t            dec, out_q;
  logic            out_valid_q;
  logic            accept;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign fn_field = instr[5:0];

  // Register file; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Combinational reads with bypass of the write landing this same edge.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (wb_en && (wb_addr == rs)) rs_val = wb_data;
    if (wb_en && (wb_addr == rt)) rt_val = wb_data;
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end

  // Decoder; anything unrecognised becomes an all-zero entry flagged illegal.
  always_comb begin
    dec = '0;
    if (opcode == OP_RTYPE && fn_field == FN_ADDU) begin
      dec.funct = ALU_ADDU;
      dec.data1 = rs_val;
      dec.data2 = rt_val;
      dec.rd    = rd;
    end else if (opcode == OP_RTYPE && fn_field == FN_SUBU) begin
      dec.funct = ALU_SUBU;
      dec.data1 = rs_val;
      dec.data2 = rt_val;
      dec.rd    = rd;
    end else if (opcode == OP_RTYPE && fn_field == FN_SLL) begin
      dec.funct = ALU_SLL;
      dec.data1 = rt_val;
      dec.shamt = instr[10:6];
      dec.rd    = rd;
    end else if (opcode == OP_RTYPE && fn_field == FN_SLLV) begin
      // Variable shift: the amount travels in data2, so shamt stays zero.
      dec.funct = ALU_SLLV;
      dec.data1 = rt_val;
      dec.data2 = rs_val;
      dec.rd    = rd;
    end else if (opcode == OP_SLTI) begin
      dec.funct = ALU_SLTI;
      dec.data1 = rs_val;
      dec.data2 = {{(XLEN-IMMW){instr[15]}}, instr[15:0]};
      dec.rd    = rt;
    end else begin
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Output entry: load on accept, drop on consume or flush, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= dec;
    end else if (flush || out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign data1     = out_q.data1;
  assign data2     = out_q.data2;
  assign shamt     = out_q.shamt;
  assign funct     = out_q.funct;
  assign rd_out    = out_q.rd;
  assign illegal   = out_q.illegal;

endmodule
